// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned INSTR_BYTES     = 4;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP,
        ST_ERR
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_slot_t;

    // Force a target address onto an instruction boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Response wait counter: clears on request/redirect, counts idle wait cycles,
// flags the cycle in which the count would reach TIMEOUT.
module fetch_timer
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    assign expire_c = enable && (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire_c) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, IF/ID slot,
// redirect handling and sticky response-timeout error.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        fetch_err
);

    fetch_state_t state;
    fetch_slot_t  slot;

    logic slot_free_c;
    logic capture_c;
    logic timer_clear_c;
    logic timer_en_c;
    logic expire_c;

    assign slot_free_c = !id_valid || id_ready;
    assign imem_addr   = pc_cur;
    assign id_instr    = slot.instr;
    assign id_pc       = slot.pc;

    // Request, next-PC and capture decisions for the current cycle.
    always_comb begin
        imem_req  = 1'b0;
        pc_next   = pc_cur;
        capture_c = 1'b0;
        if (!reset) begin
            unique case (state)
                ST_IDLE: begin
                    if (redirect_valid) begin
                        pc_next = align_pc(redirect_pc);
                    end else if (slot_free_c) begin
                        imem_req = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        pc_next = align_pc(redirect_pc);
                    end else if (imem_rvalid) begin
                        pc_next   = pc_cur + 32'(INSTR_BYTES);
                        capture_c = 1'b1;
                    end
                end
                ST_DROP: begin
                    if (redirect_valid) begin
                        pc_next = align_pc(redirect_pc);
                    end
                end
                ST_ERR: begin
                    pc_next = pc_cur;
                end
            endcase
        end
    end

    // Counter restarts whenever WAIT or DROP is (re)entered.
    assign timer_clear_c = imem_req
                        || ((state == ST_WAIT) && redirect_valid && !imem_rvalid);
    assign timer_en_c    = ((state == ST_WAIT) || (state == ST_DROP)) && !imem_rvalid;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear_c),
        .enable   (timer_en_c),
        .expire_c (expire_c)
    );

    // State register plus the registered IF/ID slot and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            id_valid  <= 1'b0;
            slot      <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (capture_c) begin
                id_valid <= 1'b1;
                slot     <= '{instr: imem_rdata, pc: pc_cur};
            end else if (redirect_valid && (state != ST_ERR)) begin
                id_valid <= 1'b0;
            end else if (id_valid && id_ready) begin
                id_valid <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (imem_req) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state <= ST_IDLE;
                    end else if (redirect_valid) begin
                        state <= ST_DROP;
                    end else if (expire_c) begin
                        state     <= ST_ERR;
                        fetch_err <= 1'b1;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid) begin
                        state <= ST_IDLE;
                    end else if (expire_c) begin
                        state     <= ST_ERR;
                        fetch_err <= 1'b1;
                    end
                end
                ST_ERR: begin
                    state <= ST_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: PC register, imem responder, per-cycle
// transaction-level model and hand-computed spot checks.
module tb_fetch_ctrl;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        fetch_err;

    logic        pc_load_en;
    logic [31:0] pc_load_val;

    int          checks = 0;
    int          errors = 0;

    int          mem_lat;
    bit          stray_rv;
    bit          req_seen;
    logic [31:0] req_addr;
    logic [31:0] resp_addr;
    int          resp_cnt;

    bit          m_out, m_drop, m_err, m_sv;
    int          m_wc;
    logic [31:0] m_si, m_sp;

    fetch_ctrl #(.TIMEOUT(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_cur         (pc_cur),
        .pc_next        (pc_next),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pc_cur <= pc_load_en ? pc_load_val : pc_next;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[15:0], 16'h0013} ^ 32'h0000_5A00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory: answers each sampled request mem_lat cycles later (0 = never).
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        resp_cnt    = 0;
        resp_addr   = 32'h0;
        forever begin
            @(negedge clk);
            req_seen = imem_req;
            req_addr = imem_addr;
            @(posedge clk);
            #2;
            if (reset) begin
                resp_cnt = 0;
            end else if (req_seen && mem_lat > 0) begin
                resp_cnt  = mem_lat;
                resp_addr = req_addr;
            end
            imem_rvalid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(resp_addr);
                end
            end
            if (stray_rv) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    // Transaction-level model: outstanding/discard flags, wait age, slot contents.
    initial begin
        bit          free, e_req, capture;
        logic [31:0] e_pcn;
        bit          n_out, n_drop, n_err, n_sv;
        int          n_wc;
        logic [31:0] n_si, n_sp;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_out = 0; m_drop = 0; m_err = 0; m_sv = 0; m_wc = 0;
                m_si = 32'h0; m_sp = 32'h0;
            end
            free  = !m_sv || id_ready;
            e_req = !reset && !m_err && !m_out && !redirect_valid && free;
            e_pcn = pc_cur;
            if (!reset && !m_err) begin
                if (redirect_valid) e_pcn = redirect_pc & 32'hFFFF_FFFC;
                else if (m_out && !m_drop && imem_rvalid) e_pcn = pc_cur + 32'd4;
            end
            check("m_imem_req", 32'(imem_req), 32'(e_req));
            if (e_req) check("m_imem_addr", imem_addr, pc_cur);
            check("m_pc_next", pc_next, e_pcn);
            check("m_id_valid", 32'(id_valid), 32'(m_sv));
            check("m_id_instr", id_instr, m_si);
            check("m_id_pc", id_pc, m_sp);
            check("m_fetch_err", 32'(fetch_err), 32'(m_err));

            n_out = m_out; n_drop = m_drop; n_err = m_err; n_sv = m_sv;
            n_wc = m_wc; n_si = m_si; n_sp = m_sp;
            capture = !reset && !m_err && m_out && !m_drop && imem_rvalid && !redirect_valid;
            if (capture) begin
                n_sv = 1; n_si = imem_rdata; n_sp = pc_cur;
            end else if (redirect_valid && !m_err) begin
                n_sv = 0;
            end else if (m_sv && id_ready) begin
                n_sv = 0;
            end
            if (!m_err) begin
                if (e_req) begin
                    n_out = 1; n_drop = 0; n_wc = 0;
                end else if (m_out && imem_rvalid) begin
                    n_out = 0; n_drop = 0;
                end else if (m_out && !m_drop && redirect_valid) begin
                    n_drop = 1; n_wc = 0;
                end else if (m_out) begin
                    n_wc = m_wc + 1;
                    if (n_wc >= int'(TMO)) begin
                        n_err = 1; n_out = 0;
                    end
                end
            end
            @(posedge clk);
            if (!reset) begin
                m_out = n_out; m_drop = n_drop; m_err = n_err; m_sv = n_sv;
                m_wc = n_wc; m_si = n_si; m_sp = n_sp;
            end
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        reset = 1'b1; pc_load_en = 1'b1; pc_load_val = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        id_ready = 1'b1; mem_lat = 1; stray_rv = 1'b0;
        cyc(); cyc(); #2;
        check("rst_id_valid", 32'(id_valid), 32'h0);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_fetch_err", 32'(fetch_err), 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_pc_next", pc_next, 32'h0);

        // Basic fetch from 0 with single-cycle memory.
        cyc(); reset = 1'b0; pc_load_en = 1'b0; #2;
        check("t1_req", 32'(imem_req), 32'h1);
        check("t1_addr", imem_addr, 32'h0);
        cyc(); #2;
        check("t1_pc_next", pc_next, 32'h4);
        cyc(); id_ready = 1'b0; #2;
        check("t1_id_valid", 32'(id_valid), 32'h1);
        check("t1_id_pc", id_pc, 32'h0);
        check("t1_id_instr", id_instr, 32'h0050_0093);

        // Back-pressure: slot full for five cycles.
        check("t2_stall_req", 32'(imem_req), 32'h0);
        check("t2_stall_pc", pc_next, 32'h4);
        for (int i = 0; i < 4; i++) begin
            cyc(); #2;
            check("t2_stall_req", 32'(imem_req), 32'h0);
            check("t2_stall_pc", pc_next, 32'h4);
        end
        cyc(); id_ready = 1'b1; #2;
        check("t2_release_req", 32'(imem_req), 32'h1);
        check("t2_release_addr", imem_addr, 32'h4);
        cyc(); #2;
        check("t2_pc_next", pc_next, 32'h8);

        // Redirect to 0x103 while waiting; late response is dropped.
        cyc(); mem_lat = 3; #2;
        check("t3_req", 32'(imem_req), 32'h1);
        check("t3_id_pc", id_pc, 32'h4);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #2;
        check("t3_redir_pc", pc_next, 32'h0000_0100);
        check("t3_redir_req", 32'(imem_req), 32'h0);
        cyc(); redirect_valid = 1'b0; #2;
        check("t3_drop_valid", 32'(id_valid), 32'h0);
        cyc(); #2;
        check("t3_drop_pc", pc_next, 32'h0000_0100);
        cyc(); mem_lat = 2; #2;
        check("t3_after_valid", 32'(id_valid), 32'h0);
        check("t3_after_req", 32'(imem_req), 32'h1);
        check("t3_after_addr", imem_addr, 32'h0000_0100);

        // Redirect coincident with the response.
        cyc(); #2;
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; #2;
        check("t4_redir_pc", pc_next, 32'h0000_0200);
        cyc(); redirect_valid = 1'b0; #2;
        check("t4_no_capture", 32'(id_valid), 32'h0);
        check("t4_idle_req", 32'(imem_req), 32'h1);
        check("t4_idle_addr", imem_addr, 32'h0000_0200);

        // Redirect to the top of the address space, then wrap to zero.
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; #2;
        check("t5_redir_pc", pc_next, 32'hFFFF_FFFC);
        cyc(); redirect_valid = 1'b0; mem_lat = 1; #2;
        check("t5_drop_pc", pc_next, 32'hFFFF_FFFC);
        cyc(); #2;
        check("t5_req", 32'(imem_req), 32'h1);
        check("t5_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(); #2;
        check("t5_wrap", pc_next, 32'h0);
        cyc(); mem_lat = 0; #2;
        check("t5_id_pc", id_pc, 32'hFFFF_FFFC);
        check("t5_id_instr", id_instr, mem_word(32'hFFFF_FFFC));
        check("t6_req", 32'(imem_req), 32'h1);

        // No response: timeout after four wait cycles.
        for (int i = 0; i < 4; i++) begin
            cyc(); #2;
            check("t6_wait_err", 32'(fetch_err), 32'h0);
            check("t6_wait_req", 32'(imem_req), 32'h0);
        end
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0040; stray_rv = 1'b1; #2;
        check("t6_err", 32'(fetch_err), 32'h1);
        check("t6_err_req", 32'(imem_req), 32'h0);
        check("t6_err_pc", pc_next, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(); redirect_valid = 1'b0; stray_rv = 1'b0; #2;
            check("t6_err_hold", 32'(fetch_err), 32'h1);
            check("t6_err_hold_req", 32'(imem_req), 32'h0);
        end

        // Reset recovers; reset mid-wait; stray response after reset ignored.
        cyc(); reset = 1'b1; #2;
        check("t7_rst_err", 32'(fetch_err), 32'h0);
        check("t7_rst_req", 32'(imem_req), 32'h0);
        check("t7_rst_pc", pc_next, 32'h0);
        cyc(); reset = 1'b0; #2;
        check("t7_req", 32'(imem_req), 32'h1);
        cyc(); #2;
        cyc(); reset = 1'b1; #2;
        check("t7_midwait_req", 32'(imem_req), 32'h0);
        check("t7_midwait_pc", pc_next, 32'h0);
        cyc(); reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; stray_rv = 1'b1; #2;
        check("t7_stray_req", 32'(imem_req), 32'h0);
        check("t7_stray_pc", pc_next, 32'h0000_0300);
        cyc(); redirect_valid = 1'b0; stray_rv = 1'b0; mem_lat = 1; #2;
        check("t7_stray_valid", 32'(id_valid), 32'h0);
        check("t7_req2", 32'(imem_req), 32'h1);
        check("t7_addr2", imem_addr, 32'h0000_0300);
        cyc(); #2;
        check("t7_pc_next", pc_next, 32'h0000_0304);
        cyc(); #2;
        check("t7_id_pc", id_pc, 32'h0000_0300);
        check("t7_id_instr", id_instr, mem_word(32'h0000_0300));
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
